// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor for the 5-stage MIPS core: direct-mapped BTB with 2-bit
// counters, looked up in IF and resolved in ID, plus saturating branch/mispredict counters.
module branch_predict_ctrl #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             equalR,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [PC_W-1:0]  id_target,
  input  logic             id_pred_taken,
  input  logic [PC_W-1:0]  id_pred_target,
  output logic [1:0]       pc_sel,
  output logic             if_flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_reg  [ENTRIES];
  logic [TAG_W-1:0] tag_reg    [ENTRIES];
  logic [PC_W-1:0]  target_reg [ENTRIES];
  logic [1:0]       ctr_reg    [ENTRIES];

  logic [CNT_W-1:0] br_cnt_reg;
  logic [CNT_W-1:0] mp_cnt_reg;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             if_hit;
  logic             id_hit;
  logic             res;
  logic             is_br;
  logic             act;
  logic             mp;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[PC_W-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

  // IF lookup reads the current array state, so a same-cycle update is not visible yet.
  assign if_hit      = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign pred_taken  = !rst && if_hit && ctr_reg[if_idx][1];
  assign pred_target = target_reg[if_idx];

  assign id_hit = valid_reg[id_idx] && (tag_reg[id_idx] == id_tag);
  assign res    = !rst && id_valid && !id_stall;
  assign is_br  = id_beq || id_bne;
  assign act    = id_beq ? equalR : !equalR;
  assign mp     = res && ((is_br && (act != id_pred_taken)) ||
                          (is_br && act && id_pred_taken && (id_pred_target != id_target)) ||
                          (!is_br && id_pred_taken));

  always_comb begin
    pc_sel   = 2'b00;
    if_flush = 1'b0;
    if (mp) begin
      if_flush = 1'b1;
      pc_sel   = (is_br && act) ? 2'b10 : 2'b11;
    end else if (rst || id_stall) begin
      pc_sel = 2'b00;
    end else if (pred_taken) begin
      pc_sel = 2'b01;
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi]  <= 1'b0;
          tag_reg[gi]    <= '0;
          target_reg[gi] <= '0;
          ctr_reg[gi]    <= 2'b01;
        end else if (res && (id_idx == IDX_W'(gi))) begin
          if (is_br) begin
            if (id_hit) begin
              if (act) begin
                target_reg[gi] <= id_target;
                if (ctr_reg[gi] != 2'b11) ctr_reg[gi] <= ctr_reg[gi] + 2'b01;
              end else if (ctr_reg[gi] != 2'b00) begin
                ctr_reg[gi] <= ctr_reg[gi] - 2'b01;
              end
            end else if (act) begin
              valid_reg[gi]  <= 1'b1;
              tag_reg[gi]    <= id_tag;
              target_reg[gi] <= id_target;
              ctr_reg[gi]    <= 2'b10;
            end
          end else if (id_pred_taken) begin
            // Non-branch predicted taken: a tag alias, so drop the entry.
            valid_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_reg <= '0;
      mp_cnt_reg <= '0;
    end else begin
      if (res && is_br && (br_cnt_reg != '1)) br_cnt_reg <= br_cnt_reg + 1'b1;
      if (mp && (mp_cnt_reg != '1))           mp_cnt_reg <= mp_cnt_reg + 1'b1;
    end
  end

  assign br_cnt = br_cnt_reg;
  assign mp_cnt = mp_cnt_reg;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl; narrow statistics counters make saturation reachable.
module tb_branch_predict_ctrl;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [PC_W-1:0]  if_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             id_valid, id_stall, id_beq, id_bne, equalR, id_pred_taken;
  logic [PC_W-1:0]  id_pc, id_target, id_pred_target;
  logic [1:0]       pc_sel;
  logic             if_flush;
  logic [CNT_W-1:0] br_cnt, mp_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  branch_predict_ctrl #(.PC_W(PC_W), .ENTRIES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .id_valid(id_valid), .id_stall(id_stall), .id_beq(id_beq), .id_bne(id_bne),
    .equalR(equalR), .id_pc(id_pc), .id_target(id_target), .id_pred_taken(id_pred_taken),
    .id_pred_target(id_pred_target), .pc_sel(pc_sel), .if_flush(if_flush),
    .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%0h", tag, got);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic st, input logic beq, input logic bne,
                        input logic eq, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    id_valid = v; id_stall = st; id_beq = beq; id_bne = bne; equalR = eq;
    id_pc = pc; id_target = tgt; id_pred_taken = pt; id_pred_target = ptgt;
  endtask

  task automatic idle();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h40;
    // A would-be mispredicting branch during reset must be ignored.
    set_id(1, 0, 1, 0, 1, 32'h40, 32'h80, 0, 32'h0);
    #1;
    check("rst_pc_sel", pc_sel, 0);
    check("rst_flush", if_flush, 0);
    check("rst_pred", pred_taken, 0);
    cycle();
    cycle();
    rst = 1'b0;
    idle();
    #1;
    check("init_pred", pred_taken, 0);
    check("init_pc_sel", pc_sel, 0);
    check("init_br", br_cnt, 0);
    check("init_mp", mp_cnt, 0);

    // Bubble in ID is ignored.
    set_id(0, 0, 1, 0, 1, 32'h40, 32'h80, 0, 32'h0);
    #1;
    check("bubble_flush", if_flush, 0);
    cycle();
    check("bubble_br", br_cnt, 0);
    check("bubble_pred", pred_taken, 0);

    // First taken beq: allocate, ctr=10.
    set_id(1, 0, 1, 0, 1, 32'h40, 32'h80, 0, 32'h0);
    #1;
    check("alloc_pc_sel", pc_sel, 2'b10);
    check("alloc_flush", if_flush, 1);
    check("alloc_old_look", pred_taken, 0);
    cycle();
    idle();
    #1;
    check("alloc_pred", pred_taken, 1);
    check("alloc_target", pred_target, 32'h80);
    check("alloc_pc_sel2", pc_sel, 2'b01);
    check("alloc_br", br_cnt, 1);
    check("alloc_mp", mp_cnt, 1);

    // Two correct taken predictions: ctr 10->11->11.
    for (int i = 0; i < 2; i++) begin
      set_id(1, 0, 1, 0, 1, 32'h40, 32'h80, 1, 32'h80);
      #1;
      check("hit_pc_sel", pc_sel, 2'b01);
      check("hit_flush", if_flush, 0);
      cycle();
    end

    // Not-taken mispredict: ctr 11->10, still predicts taken.
    set_id(1, 0, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80);
    #1;
    check("nt1_pc_sel", pc_sel, 2'b11);
    check("nt1_flush", if_flush, 1);
    cycle();
    idle();
    #1;
    check("nt1_pred", pred_taken, 1);
    check("nt1_br", br_cnt, 4);
    check("nt1_mp", mp_cnt, 2);

    // Second not-taken mispredict: ctr 10->01.
    set_id(1, 0, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80);
    #1;
    check("nt2_pc_sel", pc_sel, 2'b11);
    check("nt2_flush", if_flush, 1);
    cycle();
    idle();
    #1;
    check("nt2_pred", pred_taken, 0);
    check("nt2_br", br_cnt, 5);
    check("nt2_mp", mp_cnt, 3);

    // bne taken, stalled two cycles, then released.
    set_id(1, 1, 0, 1, 0, 32'h40, 32'h100, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_pc_sel", pc_sel, 2'b00);
      check("stall_flush", if_flush, 0);
      cycle();
      check("stall_br", br_cnt, 5);
    end
    id_stall = 1'b0;
    #1;
    check("rel_pc_sel", pc_sel, 2'b10);
    check("rel_flush", if_flush, 1);
    cycle();
    idle();
    #1;
    check("rel_br", br_cnt, 6);
    check("rel_mp", mp_cnt, 4);
    check("rel_pred", pred_taken, 1);
    check("rel_target", pred_target, 32'h100);

    // Predicted taken but wrong target.
    set_id(1, 0, 1, 0, 1, 32'h40, 32'h120, 1, 32'h100);
    #1;
    check("tgt_pc_sel", pc_sel, 2'b10);
    check("tgt_flush", if_flush, 1);
    cycle();
    idle();
    #1;
    check("tgt_target", pred_target, 32'h120);
    check("tgt_mp", mp_cnt, 5);
    check("tgt_br", br_cnt, 7);

    // Alias: add at 0x440 shares index 0 but not the tag.
    if_pc = 32'h440;
    set_id(1, 0, 0, 0, 0, 32'h440, 32'h0, 1, 32'h120);
    #1;
    check("alias_pred", pred_taken, 0);
    check("alias_pc_sel", pc_sel, 2'b11);
    check("alias_flush", if_flush, 1);
    cycle();
    idle();
    if_pc = 32'h40;
    #1;
    check("alias_inval", pred_taken, 0);
    check("alias_mp", mp_cnt, 6);
    check("alias_br", br_cnt, 7);

    // Drive mp_cnt to all-ones minus 1, then 3 more mispredicts.
    for (int i = 0; i < 8; i++) begin
      set_id(1, 0, 0, 0, 0, 32'h80, 32'h0, 1, 32'h200);
      cycle();
    end
    idle();
    #1;
    check("sat_pre_mp", mp_cnt, 14);
    for (int i = 0; i < 3; i++) begin
      set_id(1, 0, 0, 0, 0, 32'h80, 32'h0, 1, 32'h200);
      cycle();
      check("sat_mp", mp_cnt, 15);
    end
    idle();
    check("sat_br", br_cnt, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Dynamic branch-prediction controller for the 5-stage pipelined MIPS core; the parametrised successor to the static ID-stage branch handler. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters predicts `beq`/`bne` in IF. The block resolves the branch in ID using the register-equality flag, then drives PC-source select and IF/ID flush. Saturating branch and mispredict counters support performance measurement.

## Interface
Parameters:
- `PC_W`, 32, PC / target width.
- `ENTRIES`, 16, BTB entries; power of two, at least 2. `IDX_W = log2(ENTRIES)`; index is `pc[IDX_W+1:2]`; tag is `pc[PC_W-1:IDX_W+2]`.
- `CNT_W`, 16, width of each statistics counter.

Ports:
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `if_pc` in, PC_W: PC of the instruction being fetched.
- `pred_taken` out, 1: IF prediction, combinational.
- `pred_target` out, PC_W: predicted target from the BTB entry.
- `id_valid` in, 1: ID holds a real instruction (not a bubble).
- `id_stall` in, 1: load-use stall from the hazard unit.
- `id_beq` in, 1: ID instruction is `beq`.
- `id_bne` in, 1: ID instruction is `bne`.
- `equalR` in, 1: ID register comparison result.
- `id_pc` in, PC_W: PC of the ID instruction.
- `id_target` in, PC_W: computed branch target.
- `id_pred_taken` in, 1: `pred_taken`, carried through the IF/ID register.
- `id_pred_target` in, PC_W: `pred_target`, carried through the IF/ID register.
- `pc_sel` out, 2: PC source. 00 = PC+4; 01 = `pred_target`; 10 = `id_target`; 11 = `id_pc`+4.
- `if_flush` out, 1: squash the IF/ID register.
- `br_cnt` out, CNT_W: number of resolved branches.
- `mp_cnt` out, CNT_W: number of mispredicts.

## Operation
Lookup (IF, combinational):
- `hit = valid[idx] && tag[idx] == if_pc tag`.
- `pred_taken = hit && ctr[idx][1]`.
- `pred_target = target[idx]`. This value is don't-care when `pred_taken = 0`.

Resolution (ID). The resolve condition is `res = id_valid && !id_stall`.
- `is_br = id_beq || id_bne`.
- Actual outcome: `act = id_beq ? equalR : !equalR`.
- A mispredict (`mp`) occurs when `res` holds and any of the following is true:
  - `is_br` and `act != id_pred_taken`;
  - `is_br && act && id_pred_taken` and `id_pred_target != id_target`;
  - `!is_br && id_pred_taken` (phantom prediction from tag alias).

Outputs, in priority order:
1. `mp` gives `if_flush = 1`. `pc_sel = 10` if `is_br && act`, else `11`.
2. `id_stall` gives `pc_sel = 00` and `if_flush = 0`.
3. `pred_taken` gives `pc_sel = 01` and `if_flush = 0`.
4. Otherwise `pc_sel = 00` and `if_flush = 0`.

BTB update on the clock edge when `res` holds. The entry addressed by `id_pc` is updated as follows:
- `is_br`, `id_pc` hits, `act = 1`: increment `ctr`, saturating at 11; write `target = id_target`.
- `is_br`, `id_pc` hits, `act = 0`: decrement `ctr`, saturating at 00; `target` unchanged.
- `is_br`, `id_pc` misses, `act = 1`: allocate the entry (overwrite). Set `valid = 1`, write the tag, `target = id_target`, `ctr = 10`.
- `is_br`, `id_pc` misses, `act = 0`: no change.
- `!is_br && id_pred_taken`: clear `valid` for that index.

Statistics:
- `br_cnt` increments by 1 on each `res && is_br`.
- `mp_cnt` increments by 1 on each `mp`.
- Both counters saturate at all-ones and never wrap.

## Timing
- Lookup and resolution paths are purely combinational, with zero-cycle latency.
- A BTB write is visible to lookup on the cycle after the edge. If the same cycle performs a lookup and an update to the same index, the lookup sees the old contents.
- A stalled ID branch is resolved in the first cycle with `id_stall = 0`; exactly one update and at most one count occur.
- Reset:
  - Clears all `valid` bits, sets all counters to 01, and zeroes `target`, `br_cnt` and `mp_cnt`.
  - While `rst = 1`, `pc_sel = 00`, `if_flush = 0` and `pred_taken = 0`.
  - Reset asserted mid-stream discards any pending update in that cycle.
- A flushed instruction arrives in ID with `id_valid = 0` and is ignored.

## Test plan
All scenarios use `ENTRIES = 16`.
- Reset, then `if_pc = 0x40` → `pred_taken = 0`, `pc_sel = 00`, `br_cnt = mp_cnt = 0`.
- `beq` at 0x40 with `equalR = 1`, `id_pred_taken = 0`, `id_target = 0x80` → `pc_sel = 10`, `if_flush = 1`, `mp_cnt = 1`. On the next cycle, `if_pc = 0x40` gives `pred_taken = 1` and `pred_target = 0x80`.
- Same `beq` resolves taken twice more, then not-taken once → ctr sequence 10→11→11→10 (two increments from allocation, the second saturating at 11, then one decrement); `pred_taken` stays 1. A second not-taken mispredict gives `pc_sel = 11`, `if_flush = 1`, and ctr = 01.
- `bne` at 0x40 resolves with `id_stall = 1` for 2 cycles, then releases → no update or flush during the stall; exactly one increment of `br_cnt` on release.
- Alias: `add` at 0x440 (same index, different tag) with `id_pred_taken = 1` → `pc_sel = 11`, `if_flush = 1`, and entry 0 invalidated.
- Force `mp_cnt` to all-ones minus 1, then apply 3 mispredicts → `mp_cnt` holds at all-ones.
